sbox_sub_engine: RTL and testbench
==================================

Name: sbox_sub_engine

Overview:
- Multi-byte, multi-cycle byte-substitution engine. It applies the AES S-box (forward) or inverse S-box to every byte of an NUM_BYTES-wide block.
- It processes LANES bytes per clock and uses a valid/ready handshake on both input and output.
- It generalises the single-byte combinational Sbox to a parametrised, mode-selectable, sequential unit.
- It sits between state/key registers and the round datapath, in both the cipher (SubBytes) and key-expansion (SubWord, NUM_BYTES=4) paths.

Parameters:
- NUM_BYTES, 16, number of bytes per block; must be >=1.
- LANES, 4, number of bytes substituted per clock; must be >=1 and must divide NUM_BYTES.
- K = NUM_BYTES/LANES is derived: the number of substitution cycles per block.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input block is presented.
- in_ready  output  1  engine can accept a block.
- in_mode  input  1  0 = forward S-box, 1 = inverse S-box; sampled at acceptance.
- in_data  input  8*NUM_BYTES  block; byte i occupies bits [8i+7:8i].
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  8*NUM_BYTES  substituted block, same byte mapping as in_data.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset: clk and rst form a single clock domain. rst is asynchronous and active-high.
  - While rst=1: state=IDLE, group counter=0, out_valid=0, out_data=0, busy=0, in_ready=0.
  - in_ready rises in the first cycle after rst deasserts (state IDLE).
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On an edge with in_valid=1: latch in_data into the work register and in_mode into the mode register; clear the counter; go to BUSY.
  - With in_valid=0: stay in IDLE.
- BUSY: on each edge, bytes [LANES*cnt .. LANES*cnt+LANES-1] are replaced by S(byte) or InvS(byte), per the latched mode.
  - Lanes instantiate the team's forward and inverse byte-substitution modules and mux per lane on mode.
  - cnt increments on each BUSY edge.
  - On the edge that processes group K-1: go to DONE, cnt wraps to 0.
- Latency: out_valid rises exactly K edges after the acceptance edge.
  - LANES=NUM_BYTES gives 1 cycle; LANES=1 gives NUM_BYTES cycles.
- DONE:
  - out_data holds stable until an edge with out_ready=1, then go to IDLE.
  - Under backpressure (out_ready=0), out_valid and out_data hold indefinitely.
- Throughput: one block per K+2 cycles. No bypass: in_ready is 0 in the handshake cycle.
- Input stability: in_data and in_mode changes after acceptance have no effect. in_valid during BUSY/DONE is ignored and not queued.
- out_ready=1 outside DONE has no effect.
- Reset mid-operation (BUSY or DONE): the block is discarded, all outputs return to reset values, and no partial result is emitted.
- Bytes not yet processed remain unmodified in the work register; out_data is driven from the work register only in DONE, and is 0 otherwise.

Test Plan:
1. Forward, NUM_BYTES=16, LANES=4, mode=0, bytes 0..8 = 00,23,56,A3,4E,19,FF,CC,DF, remaining bytes 00.
   - Required: out_valid exactly 4 cycles after acceptance.
   - Required: bytes = 63,26,B1,0A,2F,D4,16,4B,9E, remaining 63.
2. Inverse round trip: feed test 1's result with mode=1 -> original bytes 00,23,56,A3,4E,19,FF,CC,DF,00... returned.
   - Required: InvS(63)=00, InvS(D4)=19, InvS(16)=FF.
3. Width/depth sweep.
   - NUM_BYTES=4, LANES=1, in_data=32'hFF194E00 -> out_data=32'h16D42F63 after 4 cycles.
   - LANES=NUM_BYTES=4, same input -> same output after 1 cycle.
4. Backpressure.
   - Hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_data stable, in_ready=0.
   - Then pulse out_ready -> IDLE next cycle; next block accepted K+2 cycles after the previous acceptance.
5. Ignored input: during BUSY, change in_data to all-FF and in_mode to 1 with in_valid=1 -> result matches the originally latched block/mode; no second block is produced.
6. Reset mid-operation: assert rst asynchronously (between edges) on the 2nd BUSY cycle.
   - Required: out_valid/busy=0 and out_data=0 immediately.
   - Required: after release, in_ready=1 and a fresh block completes correctly.

Source files
------------

// File: rtl/sbox_sub_engine.sv
// AES byte-substitution engine: applies the forward or inverse S-box to every
// byte of a NUM_BYTES block, LANES bytes per clock, with valid/ready on both sides.

package sbox_pkg;

  // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^127 by repeated square-and-multiply, then one square);
  // maps 0 to 0 as the S-box requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] t;
    t = a;
    for (int i = 0; i < 6; i++) begin
      t = gf_mul(gf_mul(t, t), a);
    end
    return gf_mul(t, t);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [7:0] r;
    r = (b << n) | (b >> (8 - n));
    return r;
  endfunction

  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
  endfunction

endpackage

module sbox_fwd (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import sbox_pkg::*;

  assign y = affine_fwd(gf_inv(a));
endmodule

module sbox_inv (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import sbox_pkg::*;

  assign y = gf_inv(affine_inv(a));
endmodule

module sbox_sub_engine #(
  parameter int NUM_BYTES = 16,
  parameter int LANES     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_mode,
  input  logic [8*NUM_BYTES-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_data,
  output logic                   busy
);

  localparam int K  = NUM_BYTES / LANES;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CW-1:0]          cnt;
  logic                   mode;
  logic [8*NUM_BYTES-1:0] work;
  logic [8*NUM_BYTES-1:0] work_next;
  logic                   last;
  logic [7:0]             lane_in  [LANES];
  logic [7:0]             lane_out [LANES];

  assign last = (cnt == CW'(K - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    out_data  = (state == DONE) ? work : '0;
  end

  // Pick this cycle's byte group out of the work register, one byte per lane.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      lane_in[l] = '0;
      for (int g = 0; g < K; g++) begin
        if (cnt == CW'(g)) lane_in[l] = work[(g*LANES + l)*8 +: 8];
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] fwd_y;
    logic [7:0] inv_y;

    sbox_fwd u_fwd (.a(lane_in[l]), .y(fwd_y));
    sbox_inv u_inv (.a(lane_in[l]), .y(inv_y));

    assign lane_out[l] = mode ? inv_y : fwd_y;
  end

  // Only the active group is rewritten; later groups stay as latched.
  always_comb begin
    work_next = work;
    for (int g = 0; g < K; g++) begin
      for (int l = 0; l < LANES; l++) begin
        if (cnt == CW'(g)) work_next[(g*LANES + l)*8 +: 8] = lane_out[l];
      end
    end
  end

  // NOTE: the work register is reset as well, so no stale block survives a reset
  // and out_data is deterministic from the first cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work <= '0;
      mode <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= in_data;
            mode <= in_mode;
            cnt  <= '0;
          end
        end
        BUSY: begin
          work <= work_next;
          cnt  <= last ? '0 : cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_sub_engine.sv
// Scoreboard bench for sbox_sub_engine: one 16-byte/4-lane instance plus two
// 4-byte instances (1 lane and 4 lanes) sharing their input stimulus.

module tb_sbox_sub_engine;

  localparam int K_A = 4;

  logic clk;
  logic rst;

  logic         a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_busy;
  logic [127:0] a_in_data, a_out_data;

  logic        bc_in_valid, bc_in_mode, bc_out_ready;
  logic [31:0] bc_in_data;
  logic        b_in_ready, b_out_valid, b_busy;
  logic [31:0] b_out_data;
  logic        c_in_ready, c_out_valid, c_busy;
  logic [31:0] c_out_data;

  logic [127:0] sb_a [$];
  logic [31:0]  sb_b [$];
  logic [31:0]  sb_c [$];

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  sbox_sub_engine #(.NUM_BYTES(16), .LANES(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_mode(a_in_mode), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy)
  );

  sbox_sub_engine #(.NUM_BYTES(4), .LANES(1)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(bc_in_valid), .in_ready(b_in_ready), .in_mode(bc_in_mode), .in_data(bc_in_data),
    .out_valid(b_out_valid), .out_ready(bc_out_ready), .out_data(b_out_data), .busy(b_busy)
  );

  sbox_sub_engine #(.NUM_BYTES(4), .LANES(4)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(bc_in_valid), .in_ready(c_in_ready), .in_mode(bc_in_mode), .in_data(bc_in_data),
    .out_valid(c_out_valid), .out_ready(bc_out_ready), .out_data(c_out_data), .busy(c_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference GF multiply: full polynomial product, then reduction by 0x11b.
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] m_affine(input logic [7:0] x);
    logic [7:0] c;
    logic [7:0] y;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      y[i] = x[i] ^ x[(i+4)%8] ^ x[(i+5)%8] ^ x[(i+6)%8] ^ x[(i+7)%8] ^ c[i];
    return y;
  endfunction

  function automatic logic [127:0] model16(input logic [127:0] d, input logic m);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = m ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  function automatic logic [31:0] model4(input logic [31:0] d, input logic m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m ? inv_tab[d[8*i +: 8]] : fwd_tab[d[8*i +: 8]];
    return r;
  endfunction

  task automatic send_a(input logic [127:0] d, input logic m, input logic [127:0] exp,
                        output int acc_cyc);
    check("a_ready_before_send", 128'(a_in_ready), 128'(1));
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_in_mode  = m;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    acc_cyc = cyc;
    sb_a.push_back(exp);
  endtask

  task automatic wait_out_a(input string tag);
    int lat;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!a_out_valid && lat < 100);
    check({tag, "_latency"}, 128'(lat), 128'(K_A));
  endtask

  task automatic pop_a(input string tag);
    logic [127:0] exp;
    check({tag, "_valid"}, 128'(a_out_valid), 128'(1));
    check({tag, "_sb_depth"}, 128'(sb_a.size()), 128'(1));
    exp = (sb_a.size() > 0) ? sb_a.pop_front() : '0;
    check({tag, "_data"}, a_out_data, exp);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check({tag, "_idle_after"}, 128'(a_in_ready), 128'(1));
  endtask

  task automatic run_bc(input string tag, input logic [31:0] d, input logic m,
                        input logic [31:0] exp);
    int lat_b, lat_c;
    check({tag, "_b_ready"}, 128'(b_in_ready), 128'(1));
    check({tag, "_c_ready"}, 128'(c_in_ready), 128'(1));
    bc_in_valid = 1'b1;
    bc_in_data  = d;
    bc_in_mode  = m;
    @(posedge clk); #1;
    bc_in_valid = 1'b0;
    sb_b.push_back(exp);
    sb_c.push_back(exp);
    lat_b = 0;
    lat_c = 0;
    for (int n = 1; n <= 20 && (lat_b == 0 || lat_c == 0); n++) begin
      @(posedge clk); #1;
      if (c_out_valid && lat_c == 0) begin
        lat_c = n;
        check({tag, "_c_sb_depth"}, 128'(sb_c.size()), 128'(1));
        if (sb_c.size() > 0) check({tag, "_c_data"}, 128'(c_out_data), 128'(sb_c.pop_front()));
      end
      if (b_out_valid && lat_b == 0) begin
        lat_b = n;
        check({tag, "_b_sb_depth"}, 128'(sb_b.size()), 128'(1));
        if (sb_b.size() > 0) check({tag, "_b_data"}, 128'(b_out_data), 128'(sb_b.pop_front()));
      end
    end
    check({tag, "_c_latency"}, 128'(lat_c), 128'(1));
    check({tag, "_b_latency"}, 128'(lat_b), 128'(4));
    check({tag, "_c_held"}, 128'(c_out_valid), 128'(1));
    bc_out_ready = 1'b1;
    @(posedge clk); #1;
    bc_out_ready = 1'b0;
    check({tag, "_b_idle"}, 128'(b_in_ready), 128'(1));
    check({tag, "_c_idle"}, 128'(c_in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] t1_in, t1_out, d, exp;
    logic         m;
    int           acc1, acc2;

    t1_in  = 128'h0000000000000000_dfccff194ea35623_00 >> 0;
    t1_in  = 128'h00000000000000dfccff194ea3562300;
    t1_out = 128'h636363636363639e4b16d42f0ab12663;

    rst = 1'b1;
    a_in_valid = 0; a_in_mode = 0; a_in_data = '0; a_out_ready = 0;
    bc_in_valid = 0; bc_in_mode = 0; bc_in_data = '0; bc_out_ready = 0;

    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (m_mul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      fwd_tab[a] = m_affine(inv);
    end
    for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = 8'(a);

    #12;
    check("rst_a_in_ready",  128'(a_in_ready),  128'(0));
    check("rst_a_out_valid", 128'(a_out_valid), 128'(0));
    check("rst_a_busy",      128'(a_busy),      128'(0));
    check("rst_a_out_data",  a_out_data,        128'(0));
    check("rst_b_out_data",  128'(b_out_data),  128'(0));
    check("rst_c_in_ready",  128'(c_in_ready),  128'(0));

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 128'(a_in_ready), 128'(1));

    // Forward known vector, then inverse round trip issued back-to-back.
    send_a(t1_in, 1'b0, t1_out, acc1);
    check("t1_busy", 128'(a_busy), 128'(1));
    check("t1_out_zero_busy", a_out_data, 128'(0));
    wait_out_a("t1");
    pop_a("t1");

    send_a(t1_out, 1'b1, t1_in, acc2);
    check("throughput_gap", 128'(acc2 - acc1), 128'(K_A + 2));
    wait_out_a("t2");
    check("inv_63", 128'(a_out_data[7:0]),   128'(8'h00));
    check("inv_d4", 128'(a_out_data[47:40]), 128'(8'h19));
    check("inv_16", 128'(a_out_data[55:48]), 128'(8'hff));
    pop_a("t2");

    for (int i = 0; i < 4; i++) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      m = 1'($urandom_range(0, 1));
      send_a(d, m, model16(d, m), acc1);
      wait_out_a("rand");
      pop_a("rand");
    end

    // Backpressure: hold out_ready low in DONE.
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    exp = model16(d, 1'b0);
    send_a(d, 1'b0, exp, acc1);
    wait_out_a("bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid_hold", 128'(a_out_valid), 128'(1));
      check("bp_data_hold",  a_out_data,        exp);
      check("bp_in_ready",   128'(a_in_ready),  128'(0));
    end
    pop_a("bp");

    // Inputs changed during BUSY are ignored, and nothing is queued.
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_a(d, 1'b0, model16(d, 1'b0), acc1);
    a_in_valid = 1'b1;
    a_in_data  = '1;
    a_in_mode  = 1'b1;
    check("ign_in_ready", 128'(a_in_ready), 128'(0));
    wait_out_a("ign");
    a_in_valid = 1'b0;
    pop_a("ign");
    repeat (6) @(posedge clk);
    #1;
    check("ign_no_second_valid", 128'(a_out_valid), 128'(0));
    check("ign_no_second_busy",  128'(a_busy),      128'(0));

    // Asynchronous reset during the second BUSY cycle.
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_a(d, 1'b0, model16(d, 1'b0), acc1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 128'(a_out_valid), 128'(0));
    check("mid_rst_busy",      128'(a_busy),      128'(0));
    check("mid_rst_out_data",  a_out_data,        128'(0));
    check("mid_rst_in_ready",  128'(a_in_ready),  128'(0));
    sb_a.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_release_ready", 128'(a_in_ready),  128'(1));
    check("mid_rst_release_valid", 128'(a_out_valid), 128'(0));
    d = {$urandom(), $urandom(), $urandom(), $urandom()};
    send_a(d, 1'b1, model16(d, 1'b1), acc1);
    wait_out_a("fresh");
    pop_a("fresh");

    // Width/depth sweep on the 4-byte instances.
    run_bc("sw_fwd", 32'hff194e00, 1'b0, 32'h16d42f63);
    run_bc("sw_inv", 32'h16d42f63, 1'b1, 32'hff194e00);
    for (int i = 0; i < 2; i++) begin
      logic [31:0] w;
      w = $urandom();
      m = 1'(i);
      run_bc("sw_rand", w, m, model4(w, m));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
